inst_fetch_mem: RTL and testbench
=================================

INST_FETCH_MEM -- requirements
Module: inst_fetch_mem

Interface
REQ-001 Parameter DEPTH, 64, instruction words stored; power of two, 4..1024.
REQ-002 Parameter DATA_WIDTH, 32, instruction word width; fixed at 32 for MIPS field decode.
REQ-003 Parameter PC_WIDTH, 32, program counter width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  IDLE->RUN request; ignored in other states.
REQ-007 load_en / load_idx / load_data  in  1 / log2(DEPTH) / DATA_WIDTH  program-load write port (word index).
REQ-008 load_err  out  1  one-cycle pulse: load rejected.
REQ-009 redirect_en / redirect_pc  in  1 / PC_WIDTH  branch/jump redirect (byte address).
REQ-010 out_valid out, out_ready in, 1 each  output handshake.
REQ-011 inst_out / pc_out  out  DATA_WIDTH / PC_WIDTH  fetched word and its byte address.
REQ-012 opcode 6, rs 5, rt 5, rd 5, shamt 5, funct 6, imm 16  out  decode fields of inst_out, registered with it.
REQ-013 fault  out  1  level: FAULT state.
REQ-014 busy  out  1  high in RUN.

Function
REQ-015 States IDLE, RUN, FAULT; encoding from shared package.
REQ-016 IDLE: load_en writes mem[load_idx]<=load_data at the edge; start -> RUN next edge.
REQ-017 start together with redirect_en in IDLE: pc<=redirect_pc, then RUN.
REQ-018 load_en in RUN or FAULT: no write, load_err pulses the following cycle.
REQ-019 RUN fetch slot is free when !out_valid || out_ready; on a free slot register inst_out<=mem[pc>>2], pc_out<=pc, out_valid<=1, pc<=pc+4.
REQ-020 Latency: start sampled at edge N; first out_valid=1 after edge N+1; one instruction per cycle with out_ready held high.
REQ-021 out_valid && !out_ready: all outputs and pc hold stable.
REQ-022 redirect_en in RUN has priority over stall and fetch: out_valid<=0, pc<=redirect_pc; fetch resumes the next cycle.
REQ-023 Fetch with pc[1:0]!=0 or (pc>>2)>=DEPTH: no fetch, out_valid<=0, state->FAULT.
REQ-024 FAULT: fault=1; only redirect_en exits, loading pc<=redirect_pc and entering RUN.
REQ-025 pc+4 wraps modulo 2^PC_WIDTH; a wrapped or overrun pc faults per REQ-023.
REQ-026 Decode: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=[15:0].

Reset
REQ-027 Reset low: state IDLE; pc 0; out_valid, fault, busy, load_err 0; inst_out, pc_out and all decode fields 0.
REQ-028 Reset does not clear memory contents; reset mid-RUN discards the in-flight output immediately.

Configuration
REQ-029 INST_FETCH_PARITY_EN defined: store one even-parity bit per word on load; add input load_par_flip (1) that inverts the stored bit; a fetch with parity mismatch gives out_valid<=0 and FAULT.
REQ-030 INST_FETCH_PARITY_EN undefined: no parity storage, no load_par_flip port, and parity never faults.

Structure
REQ-031 Package inst_fetch_pkg holds the state enum, the field bit-position constants and the MIPS opcode/funct constants.
REQ-032 Sub-module inst_fetch_ram holds the storage array, write port, combinational read and optional parity; inst_fetch_mem holds the FSM, pc, handshake and decode.

Verification
REQ-033 In IDLE load idx0=0x8C010004, idx1=0x00225020, then start, out_ready=1 -> cycle N+1: inst 0x8C010004, pc_out 0, opcode 0x23, rt 1, imm 4; cycle N+2: pc_out 4, rd 10, funct 0x20.
REQ-034 out_ready=0 for 3 cycles while out_valid -> inst_out and pc_out stable; pc advances only after the ready cycle.
REQ-035 redirect_pc=0x10 during a stall -> out_valid 0 next cycle, then pc_out 0x10 with mem[4].
REQ-036 redirect_pc=0x2 -> FAULT, fault=1; redirect_pc=0 -> RUN, pc_out 0; with DEPTH=64 a fetch at pc 0x100 also faults.
REQ-037 load_en in RUN -> load_err pulse, memory unchanged; reset low mid-RUN -> all outputs 0, memory retained on restart.
REQ-038 With INST_FETCH_PARITY_EN: load idx2 with load_par_flip=1, then run -> FAULT at pc 8, no valid output for it.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch block.
//   - fetch_state_t : FSM state encoding (IDLE / RUN / FAULT)
//   - *_MSB / *_LSB : MIPS instruction field bit positions used by the decoder
//   - OP_* / FUNCT_*: common MIPS opcode and funct values for consumers of the
//                     decoded fields
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  // MIPS field positions within a 32-bit instruction word
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  // MIPS opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;

endpackage

// File: rtl/inst_fetch_ram.sv
// Instruction storage for inst_fetch_mem.
// Macro: INST_FETCH_PARITY_EN adds one even-parity bit per word.
// Ports:
//   clk          - write clock
//   we           - write enable (gated by the caller to IDLE only)
//   widx / wdata - write word index and data
//   par_flip     - (parity build only) invert the stored parity bit
//   ridx         - read word index (combinational read)
//   rdata        - word at ridx
//   par_err      - stored parity disagrees with rdata (always 0 without parity)
// The array has no reset: contents survive a reset of the fetch logic.
module inst_fetch_ram #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] widx,
  input  logic [DATA_WIDTH-1:0] wdata,
`ifdef INST_FETCH_PARITY_EN
  input  logic                  par_flip,
`endif
  input  logic [ADDR_WIDTH-1:0] ridx,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  par_err
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

`ifdef INST_FETCH_PARITY_EN
  logic par_mem [DEPTH];

  // Even parity: stored bit makes word+bit have an even number of ones.
  always_ff @(posedge clk) begin
    if (we) begin
      par_mem[widx] <= (^wdata) ^ par_flip;
    end
  end

  assign par_err = (^rdata) != par_mem[ridx];
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: rtl/inst_fetch_mem.sv
// Instruction fetch unit: program-loadable instruction memory, PC sequencing
// with ready/valid output handshake, redirect, fault detection and MIPS
// field decode of the fetched word.
// Macro: INST_FETCH_PARITY_EN enables per-word parity and the load_par_flip port.
// Ports:
//   clk, reset (async, active-low)
//   start                           - IDLE -> RUN request
//   load_en/load_idx/load_data      - program load (IDLE only)
//   load_par_flip                   - (parity build) corrupt stored parity
//   load_err                        - one-cycle pulse: load rejected
//   redirect_en/redirect_pc         - branch/jump redirect (byte address)
//   out_valid/out_ready             - output handshake
//   inst_out/pc_out                 - fetched word and its byte address
//   opcode/rs/rt/rd/shamt/funct/imm - decode fields of inst_out
//   fault                           - in FAULT state
//   busy                            - in RUN state
module inst_fetch_mem
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [DATA_WIDTH-1:0]    load_data,
`ifdef INST_FETCH_PARITY_EN
  input  logic                     load_par_flip,
`endif
  output logic                     load_err,
  input  logic                     redirect_en,
  input  logic [PC_WIDTH-1:0]      redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    inst_out,
  output logic [PC_WIDTH-1:0]      pc_out,
  output logic [5:0]               opcode,
  output logic [4:0]               rs,
  output logic [4:0]               rt,
  output logic [4:0]               rd,
  output logic [4:0]               shamt,
  output logic [5:0]               funct,
  output logic [15:0]              imm,
  output logic                     fault,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);

  fetch_state_t          state;
  logic [PC_WIDTH-1:0]   pc;
  logic [AW-1:0]         fetch_idx;
  logic                  pc_ok;
  logic                  slot_free;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  par_err;
  logic                  mem_we;

  assign fetch_idx = pc[AW+1:2];
  // Word aligned and every bit above the word index clear (covers wrap too).
  assign pc_ok     = (pc[1:0] == 2'b00) && ((pc >> (AW + 2)) == '0);
  assign slot_free = !out_valid || out_ready;
  assign mem_we    = load_en && (state == ST_IDLE);

  inst_fetch_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk      (clk),
    .we       (mem_we),
    .widx     (load_idx),
    .wdata    (load_data),
`ifdef INST_FETCH_PARITY_EN
    .par_flip (load_par_flip),
`endif
    .ridx     (fetch_idx),
    .rdata    (rdata),
    .par_err  (par_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      pc        <= '0;
      out_valid <= 1'b0;
      inst_out  <= '0;
      pc_out    <= '0;
      load_err  <= 1'b0;
    end else begin
      load_err <= load_en && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (redirect_en) begin
              pc <= redirect_pc;
            end
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Redirect wins over both stall and fetch.
          if (redirect_en) begin
            out_valid <= 1'b0;
            pc        <= redirect_pc;
          end else if (slot_free) begin
            if (!pc_ok || par_err) begin
              out_valid <= 1'b0;
              state     <= ST_FAULT;
            end else begin
              inst_out  <= rdata;
              pc_out    <= pc;
              out_valid <= 1'b1;
              pc        <= pc + PC_WIDTH'(4);
            end
          end
        end
        ST_FAULT: begin
          if (redirect_en) begin
            pc    <= redirect_pc;
            state <= ST_RUN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fault = (state == ST_FAULT);
  assign busy  = (state == ST_RUN);

  // Decode fields are slices of the registered word, so they update with it.
  assign opcode = inst_out[OPCODE_MSB:OPCODE_LSB];
  assign rs     = inst_out[RS_MSB:RS_LSB];
  assign rt     = inst_out[RT_MSB:RT_LSB];
  assign rd     = inst_out[RD_MSB:RD_LSB];
  assign shamt  = inst_out[SHAMT_MSB:SHAMT_LSB];
  assign funct  = inst_out[FUNCT_MSB:FUNCT_LSB];
  assign imm    = inst_out[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Testbench for inst_fetch_mem (DEPTH=64). A memory image plus an expected
// accept-order PC stream forms the reference; a negedge monitor checks every
// valid output against it, and the directed sequence pins literal values.
// Macro: INST_FETCH_PARITY_EN adds the parity-fault scenario.
module tb_inst_fetch_mem;
  import inst_fetch_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_idx = '0;
  logic [31:0]   load_data = '0;
  logic          load_err;
  logic          redirect_en = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   inst_out;
  logic [31:0]   pc_out;
  logic [5:0]    opcode;
  logic [4:0]    rs, rt, rd, shamt;
  logic [5:0]    funct;
  logic [15:0]   imm;
  logic          fault;
  logic          busy;
`ifdef INST_FETCH_PARITY_EN
  logic          load_par_flip = 1'b0;
`endif

  inst_fetch_mem #(.DEPTH(DEPTH), .DATA_WIDTH(32), .PC_WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .load_en     (load_en),
    .load_idx    (load_idx),
    .load_data   (load_data),
`ifdef INST_FETCH_PARITY_EN
    .load_par_flip (load_par_flip),
`endif
    .load_err    (load_err),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .inst_out    (inst_out),
    .pc_out      (pc_out),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .funct       (funct),
    .imm         (imm),
    .fault       (fault),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_pc = '0;
  logic        hold_prev = 1'b0;
  logic [31:0] prev_inst = '0;
  logic [31:0] prev_pc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid output must be the stored word at pc_out with the
  // MIPS field split, accepted words must follow the expected PC stream,
  // and a stalled output must not change.
  always @(negedge clk) begin
    logic [31:0] w;
    if (!reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_inst", inst_out, prev_inst);
        check("stall_pc", pc_out, prev_pc);
      end
      if (out_valid) begin
        w = model_mem[pc_out[AW+1:2]];
        check("mon_pc_legal", {31'd0, (pc_out < 32'(DEPTH * 4)) && (pc_out[1:0] == 2'b00)}, 32'd1);
        check("mon_inst", inst_out, w);
        check("mon_fields", {opcode, rs, rt, rd, shamt, funct},
              {w[31:26], w[25:21], w[20:16], w[15:11], w[10:6], w[5:0]});
        check("mon_imm", {16'd0, imm}, {16'd0, w[15:0]});
        if (out_ready) begin
          check("mon_pc_order", pc_out, exp_pc);
          exp_pc = exp_pc + 32'd4;
        end
      end
      check("mon_fault_excl", {31'd0, fault && (out_valid || busy)}, 32'd0);
      hold_prev = out_valid && !out_ready && !redirect_en;
      prev_inst = inst_out;
      prev_pc   = pc_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = 32'h2000_0000 | (32'(i) << 16) | 32'(i * 3);
    end
    model_mem[0]  = 32'h8C01_0004;
    model_mem[1]  = 32'h0022_5020;
    model_mem[2]  = 32'h2008_0005;
    model_mem[3]  = 32'hAC02_0008;
    model_mem[4]  = 32'h1000_FFFF;
    model_mem[5]  = 32'h0800_0001;
    model_mem[63] = 32'hDEAD_BEEF;

    // Reset values
    tick; tick;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_load_err", {31'd0, load_err}, 32'd0);
    check("rst_inst", inst_out, 32'd0);
    check("rst_pc", pc_out, 32'd0);
    check("rst_fields", {26'd0, opcode} | {27'd0, rd} | {16'd0, imm}, 32'd0);
    reset = 1'b1;

    // Program load in IDLE
    for (int i = 0; i < DEPTH; i++) begin
      load_en = 1'b1; load_idx = AW'(i); load_data = model_mem[i];
      tick;
    end
    load_en = 1'b0;
    tick;
    check("idle_load_err", {31'd0, load_err}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Start and first-output latency
    start = 1'b1; out_ready = 1'b1;
    tick;
    start = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_no_valid", {31'd0, out_valid}, 32'd0);
    tick;
    check("first_valid", {31'd0, out_valid}, 32'd1);
    check("first_inst", inst_out, 32'h8C01_0004);
    check("first_pc", pc_out, 32'h0);
    check("first_opcode", {26'd0, opcode}, {26'd0, OP_LW});
    check("first_rt", {27'd0, rt}, 32'd1);
    check("first_imm", {16'd0, imm}, 32'd4);
    tick;
    check("second_pc", pc_out, 32'h4);
    check("second_rd", {27'd0, rd}, 32'd10);
    check("second_funct", {26'd0, funct}, 32'h20);

    // Three-cycle stall on the pc 8 word
    tick;
    check("pre_stall_pc", pc_out, 32'h8);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      check("stall_hold_pc", pc_out, 32'h8);
      check("stall_hold_inst", inst_out, 32'h2008_0005);
    end
    out_ready = 1'b1;
    tick;
    check("post_stall_pc", pc_out, 32'hC);

    // Redirect during a stall
    out_ready = 1'b0;
    tick;
    check("stall_c_pc", pc_out, 32'hC);
    redirect_en = 1'b1; redirect_pc = 32'h10; exp_pc = 32'h10;
    tick;
    redirect_en = 1'b0;
    check("redir_bubble", {31'd0, out_valid}, 32'd0);
    tick;
    check("redir_valid", {31'd0, out_valid}, 32'd1);
    check("redir_pc", pc_out, 32'h10);
    check("redir_inst", inst_out, 32'h1000_FFFF);
    out_ready = 1'b1;
    tick;
    check("redir_next_pc", pc_out, 32'h14);

    // Misaligned redirect faults, redirect to 0 recovers
    out_ready = 1'b0;
    redirect_en = 1'b1; redirect_pc = 32'h2;
    tick;
    redirect_en = 1'b0;
    check("mis_bubble", {31'd0, out_valid}, 32'd0);
    check("mis_not_yet", {31'd0, fault}, 32'd0);
    tick;
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_no_valid", {31'd0, out_valid}, 32'd0);
    tick;
    check("fault_sticky", {31'd0, fault}, 32'd1);
    redirect_en = 1'b1; redirect_pc = 32'h0; exp_pc = 32'h0;
    tick;
    redirect_en = 1'b0;
    check("recover_busy", {31'd0, busy}, 32'd1);
    check("recover_fault", {31'd0, fault}, 32'd0);
    out_ready = 1'b1;
    tick;
    check("recover_pc", pc_out, 32'h0);
    check("recover_inst", inst_out, 32'h8C01_0004);

    // Last word, then overrun at 0x100
    out_ready = 1'b0;
    redirect_en = 1'b1; redirect_pc = 32'hFC; exp_pc = 32'hFC;
    tick;
    redirect_en = 1'b0;
    out_ready = 1'b1;
    tick;
    check("last_pc", pc_out, 32'hFC);
    check("last_inst", inst_out, 32'hDEAD_BEEF);
    tick;
    check("overrun_fault", {31'd0, fault}, 32'd1);
    check("overrun_no_valid", {31'd0, out_valid}, 32'd0);

    // Load in RUN is rejected
    redirect_en = 1'b1; redirect_pc = 32'h0; exp_pc = 32'h0;
    tick;
    redirect_en = 1'b0;
    load_en = 1'b1; load_idx = AW'(1); load_data = 32'hFFFF_FFFF;
    tick;
    load_en = 1'b0;
    check("run_load_err", {31'd0, load_err}, 32'd1);
    tick;
    check("run_load_err_pulse", {31'd0, load_err}, 32'd0);
    check("run_load_nowrite", inst_out, 32'h0022_5020);

    // Reset mid-RUN clears outputs immediately; memory retained
    #2;
    reset = 1'b0;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_inst", inst_out, 32'd0);
    check("midrst_pc", pc_out, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    exp_pc = 32'h0;
    tick;
    reset = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    check("restart_pc", pc_out, 32'h0);
    check("restart_inst", inst_out, 32'h8C01_0004);
    tick;
    check("restart_inst1", inst_out, 32'h0022_5020);

`ifdef INST_FETCH_PARITY_EN
    // Corrupted parity at word 2 faults the fetch at pc 8
    #2;
    reset = 1'b0;
    exp_pc = 32'h0;
    tick;
    reset = 1'b1;
    load_en = 1'b1; load_idx = AW'(2); load_data = model_mem[2]; load_par_flip = 1'b1;
    tick;
    load_en = 1'b0; load_par_flip = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    check("par_pc4", pc_out, 32'h4);
    tick;
    check("par_fault", {31'd0, fault}, 32'd1);
    check("par_no_valid", {31'd0, out_valid}, 32'd0);
    check("par_last_pc", pc_out, 32'h4);
`endif

    out_ready = 1'b0;
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
